// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences instruction-fetch and data load/store accesses onto
// a single shared memory bus with round-robin arbitration, byte-lane
// selection, store-data replication, load extension and a bus timeout.
// Optional build macro: MISALIGN_TRAP_EN (misaligned half/word accesses and
// misaligned fetches are rejected with err instead of being word-aligned).
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic        GRANT_FETCH = 1'b0;
  localparam logic        GRANT_DATA  = 1'b1;
  // Last BUSY cycle index before the access is abandoned.
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  // Byte-lane enables for a data access of the given size.
  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] alo);
    logic [3:0] v_sel;
    case (size)
      2'b00:   v_sel = 4'b0001 << alo;
      2'b01:   v_sel = 4'b0011 << {alo[1], 1'b0};
      2'b10:   v_sel = 4'b1111;
      default: v_sel = 4'b0000;
    endcase
    return v_sel;
  endfunction

  // Replicate LSB-aligned store data across every lane it could land in.
  function automatic logic [31:0] f_repl(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] v_data;
    case (size)
      2'b00:   v_data = {4{wdata[7:0]}};
      2'b01:   v_data = {2{wdata[15:0]}};
      default: v_data = wdata;
    endcase
    return v_data;
  endfunction

  // Move the addressed lane to bit 0 and sign/zero extend it.
  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] alo,
                                            input logic [31:0] word);
    logic [31:0] v_shift;
    logic [31:0] v_res;
    case (f3[1:0])
      2'b00:   v_shift = word >> {alo, 3'b000};
      2'b01:   v_shift = word >> {alo[1], 4'b0000};
      default: v_shift = word;
    endcase
    case (f3)
      3'b000:  v_res = {{24{v_shift[7]}}, v_shift[7:0]};
      3'b001:  v_res = {{16{v_shift[15]}}, v_shift[15:0]};
      3'b100:  v_res = {24'h000000, v_shift[7:0]};
      3'b101:  v_res = {16'h0000, v_shift[15:0]};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  // Legality of the read/write/funct3 combination, ignoring alignment.
  function automatic logic f_data_legal(input logic rd, input logic wr, input logic [2:0] f3);
    logic v_ok;
    if (rd && wr) begin
      v_ok = 1'b0;
    end else if (rd) begin
      v_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
    end else begin
      v_ok = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    end
    return v_ok;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_owner;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_alo;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_err;
  logic [31:0] r_rdata;

  logic w_d_pend;
  logic w_grant_any;
  logic w_grant_data;
  logic w_d_misalign;
  logic w_i_misalign;
  logic w_legal;
  logic w_tmo;
  logic w_busy;
  logic w_resp;

`ifdef MISALIGN_TRAP_EN
  assign w_d_misalign = ((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                        ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));
  assign w_i_misalign = (i_addr[1:0] != 2'b00);
`else
  assign w_d_misalign = 1'b0;
  assign w_i_misalign = 1'b0;
`endif

  // Round-robin: on contention the requester that did not win last time goes.
  assign w_d_pend     = d_read | d_write;
  assign w_grant_any  = i_req | w_d_pend;
  assign w_grant_data = w_d_pend & (~i_req | (r_last_grant == GRANT_FETCH));
  assign w_legal      = w_grant_data ? (f_data_legal(d_read, d_write, d_funct3) & ~w_d_misalign)
                                     : ~w_i_misalign;
  // A mem_ack on the last allowed cycle wins over the timeout.
  assign w_tmo        = (r_cnt == TMO_LAST) & ~mem_ack;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_any) begin
          w_state_nxt = w_legal ? ST_BUSY : ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack || w_tmo) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Access latch on grant, timeout counter and result capture.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_grant <= GRANT_FETCH;
      r_owner      <= GRANT_FETCH;
      r_cnt        <= 16'h0000;
      r_addr       <= 32'h0000_0000;
      r_alo        <= 2'b00;
      r_we         <= 1'b0;
      r_sel        <= 4'b0000;
      r_wdata      <= 32'h0000_0000;
      r_funct3     <= 3'b000;
      r_err        <= 1'b0;
      r_rdata      <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_last_grant <= w_grant_data;
            r_owner      <= w_grant_data;
            r_cnt        <= 16'h0000;
            r_err        <= ~w_legal;
            r_rdata      <= 32'h0000_0000;
            if (w_grant_data == GRANT_DATA) begin
              r_addr   <= {d_addr[31:2], 2'b00};
              r_alo    <= d_addr[1:0];
              r_we     <= d_write;
              r_sel    <= f_sel(d_funct3[1:0], d_addr[1:0]);
              r_wdata  <= f_repl(d_funct3[1:0], d_wdata);
              r_funct3 <= d_funct3;
            end else begin
              r_addr   <= {i_addr[31:2], 2'b00};
              r_alo    <= i_addr[1:0];
              r_we     <= 1'b0;
              r_sel    <= 4'b1111;
              r_wdata  <= 32'h0000_0000;
              r_funct3 <= 3'b010;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem_ack) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'h0000_0000 : f_extract(r_funct3, r_alo, mem_rdata);
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0000_0000;
          end
        end
        ST_RESP: begin
          r_cnt   <= 16'h0000;
          r_err   <= 1'b0;
          r_rdata <= 32'h0000_0000;
        end
        default: begin
          r_cnt <= 16'h0000;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so reset clears them at once.
  assign w_busy    = (r_state == ST_BUSY);
  assign w_resp    = (r_state == ST_RESP);
  assign mem_req   = w_busy;
  assign mem_we    = w_busy & r_we;
  assign mem_sel   = w_busy ? r_sel : 4'b0000;
  assign mem_addr  = w_busy ? r_addr : 32'h0000_0000;
  assign mem_wdata = w_busy ? r_wdata : 32'h0000_0000;
  assign i_ack     = w_resp & (r_owner == GRANT_FETCH);
  assign d_ack     = w_resp & (r_owner == GRANT_DATA);
  assign err       = w_resp & r_err;
  assign i_rdata   = i_ack ? r_rdata : 32'h0000_0000;
  assign d_rdata   = d_ack ? r_rdata : 32'h0000_0000;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences all CPU accesses onto the single shared memory bus.
- Arbitrates between two requesters: instruction fetch, and data load/store (driven by the decoder's read/write/funct3 outputs).
- Handles byte-lane selection, store-data replication, and load sign/zero extension.
- Times out hung bus transactions.

Parameters:
TIMEOUT_CYCLES, 255, cycles BUSY waits for mem_ack before aborting with error (1..65535)

Ports:
clk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
i_req  input  1  fetch request, held until i_ack
i_addr  input  32  fetch byte address
i_ack  output  1  one-cycle fetch completion pulse
i_rdata  output  32  fetched word, valid while i_ack=1
d_read  input  1  load request, held until d_ack
d_write  input  1  store request, held until d_ack
d_funct3  input  3  access size/sign (RISC-V load/store funct3)
d_addr  input  32  data byte address
d_wdata  input  32  store data, LSB-aligned
d_ack  output  1  one-cycle data completion pulse
d_rdata  output  32  extended load data, valid while d_ack=1
err  output  1  pulses with i_ack/d_ack when access failed
mem_req  output  1  bus request, held until mem_ack or timeout
mem_we  output  1  1=write
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_sel  output  4  byte-lane enables
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  bus read data, valid with mem_ack
mem_ack  input  1  bus completion, one cycle

Behaviour:
- Clock and reset: single clock, clk; reset nrst is asynchronous, active-low. On assertion, at any time including mid-transaction:
  - state=IDLE, all outputs 0, last_grant=FETCH, timeout counter=0.
  - Any in-flight bus access is abandoned, with no ack to either requester.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A data request is pending when d_read|d_write.
  - Neither request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the one not in last_grant (round-robin), so a data request wins after a fetch and vice versa.
  - On grant: latch address, we, sel, wdata, funct3 into registers and update last_grant.
  - Legal access: go to BUSY with mem_req=1 from the next cycle.
  - Illegal access: go directly to RESP with err=1.
- Illegal accesses:
  - d_read&d_write both high.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
- BUSY:
  - mem_req=1; mem_addr, mem_we, mem_sel and mem_wdata stay stable.
  - Counter increments each cycle.
  - mem_ack=1: capture mem_rdata into the result register, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, go to RESP with err=1 and rdata=0.
  - A mem_ack on the same cycle as timeout counts as success.
- RESP: pulse the granted requester's ack (plus err if set) for exactly one cycle, then return to IDLE.
  - A requester must drop its request in the cycle after its ack.
  - IDLE never sees a stale request.
- Latency with a zero-wait bus: request seen in IDLE at cycle n, mem_req at n+1, mem_ack at n+1, ack at n+2.
  - Throughput: one access per 3 cycles.
- Fetch access: always a word, mem_sel=1111, i_addr[1:0] ignored.
- mem_sel by size:
  - Byte: 0001<<addr[1:0].
  - Half: 0011<<{addr[1],1'b0}, addr[0] ignored.
  - Word: 1111, addr[1:0] ignored.
- Store data replication:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction: the selected lane is shifted to bit 0.
  - LB and LH are sign-extended from bit 7 and bit 15 respectively.
  - LBU and LHU are zero-extended.
  - LW is passed through unchanged.
- i_rdata/d_rdata are 0 except in their ack cycle.
- mem_we=0 and mem_sel=0 whenever mem_req=0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: the following accesses are illegal. They get no bus cycle, go IDLE to RESP, and pulse ack+err.
  - Half access with addr[0]=1.
  - Word data access with addr[1:0]!=0.
  - Fetch with i_addr[1:0]!=0.
- Undefined: low address bits are ignored as described above; err is raised only by illegal funct3, read&write, or timeout.

Test Plan:
- Reset mid-access: assert nrst=0 while in BUSY with mem_req=1 -> mem_req=0 immediately, no i_ack/d_ack; after release, a fresh i_req completes normally.
- Byte load, sign-extend: LB at addr 0x103, mem_rdata=0x80FF_1234 -> mem_sel=1000, mem_addr=0x100, d_rdata=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- Half store: SH at 0x202, d_wdata=0x1234_ABCD -> mem_we=1, mem_sel=1100, mem_wdata=0xABCD_ABCD, d_ack two cycles after request with zero-wait bus.
- Contention: i_req and d_read held together for 4 accesses -> grant order alternates D,F,D,F (last_grant=FETCH after reset), each ack 3 cycles apart.
- Timeout: TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high 4 cycles then low, next cycle d_ack=1, err=1, d_rdata=0.
- Misalign: LW at 0x101 -> with MISALIGN_TRAP_EN, no mem_req, d_ack+err one cycle after grant; without it, mem_addr=0x100, mem_sel=1111, err=0.
